// File: rtl/first_counter_pkg.sv
// first_counter_pkg
//   Shared constants for the first_counter utility block.
//   COUNTER_W : default counter width in bits (legal range 1..32).
package first_counter_pkg;

  localparam int COUNTER_W = 4;

endpackage : first_counter_pkg

// File: rtl/first_counter.sv
// first_counter
//   Free-running up-counter with count enable and synchronous clear.
//   The count wraps from 2^WIDTH-1 to 0 silently and the output comes
//   straight from the state register, so no input reaches it combinationally.
//
// Parameters
//   WIDTH        counter and output width in bits, 1..32 (default COUNTER_W)
//
// Ports
//   clk          rising-edge clock; all state updates on posedge
//   reset        synchronous, active-high clear; dominates enable
//   enable       active-high count enable, sampled at posedge clk
//   counter_out  current count (WIDTH bits), registered
module first_counter
  import first_counter_pkg::*;
#(
  parameter int WIDTH = COUNTER_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             enable,
  output logic [WIDTH-1:0] counter_out
);

  logic [WIDTH-1:0] r_cnt;

  // Count register: clear wins over increment, otherwise hold.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt <= {WIDTH{1'b0}};
    end else if (enable) begin
      // Truncating add gives the modulo-2^WIDTH wrap with no carry-out.
      r_cnt <= r_cnt + WIDTH'(1'b1);
    end else begin
      r_cnt <= r_cnt;
    end
  end

  assign counter_out = r_cnt;

endmodule : first_counter

// File: tb/tb_first_counter.sv
// tb_first_counter
//   Self-checking bench for first_counter. The reference model counts the
//   enabled cycles since the most recent reset as a plain integer and reduces
//   it modulo 2^W; every step is compared one edge after the inputs are sampled.
module tb_first_counter;

  localparam int W = first_counter_pkg::COUNTER_W;

  logic         clk;
  logic         reset;
  logic         enable;
  logic [W-1:0] counter_out;

  int vectors;
  int miscompares;
  int events_since_reset;
  logic model_valid;

  first_counter #(.WIDTH(W)) dut (
    .clk         (clk),
    .reset       (reset),
    .enable      (enable),
    .counter_out (counter_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare the DUT output with an expected value.
  task automatic check(input string tag, input logic [W-1:0] expected);
    vectors++;
    assert (counter_out === expected)
    else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d", tag, counter_out, expected);
    end
  endtask

  // Expected count: enabled cycles since last reset, modulo 2^W.
  function automatic logic [W-1:0] model_value();
    return W'(events_since_reset % (1 << W));
  endfunction

  // Apply one cycle of inputs, let the edge sample them, update model, compare.
  task automatic step(input logic r, input logic e, input string tag);
    @(negedge clk);
    reset  = r;
    enable = e;
    @(posedge clk);
    #1;
    if (r) begin
      events_since_reset = 0;
      model_valid = 1'b1;
    end else if (e) begin
      events_since_reset++;
    end
    if (model_valid) check(tag, model_value());
  endtask

  initial begin
    vectors            = 0;
    miscompares        = 0;
    events_since_reset = 0;
    model_valid        = 1'b0;
    reset              = 1'b0;
    enable             = 1'b0;

    // Reset with enable low, then hold at zero.
    step(1'b1, 1'b0, "reset");
    check("reset_zero", W'(0));
    for (int i = 0; i < 4; i++) step(1'b0, 1'b0, "reset_hold");
    check("reset_hold_zero", W'(0));

    // Count ten cycles, then hold.
    step(1'b1, 1'b0, "count_rst");
    for (int i = 0; i < 10; i++) step(1'b0, 1'b1, "count_up");
    check("count_ten", W'(10));
    for (int i = 0; i < 3; i++) step(1'b0, 1'b0, "count_hold");
    check("count_hold_ten", W'(10));

    // Wrap: 17 enabled cycles -> 1..15, 0, 1.
    step(1'b1, 1'b0, "wrap_rst");
    for (int i = 0; i < 15; i++) step(1'b0, 1'b1, "wrap_up");
    check("wrap_max", W'((1 << W) - 1));
    step(1'b0, 1'b1, "wrap_edge");
    check("wrap_zero", W'(0));
    step(1'b0, 1'b1, "wrap_after");
    check("wrap_one", W'(1));

    // Reset priority over enable.
    step(1'b1, 1'b0, "prio_rst");
    for (int i = 0; i < 7; i++) step(1'b0, 1'b1, "prio_up");
    check("prio_seven", W'(7));
    step(1'b1, 1'b1, "prio_both1");
    check("prio_zero1", W'(0));
    step(1'b1, 1'b1, "prio_both2");
    check("prio_zero2", W'(0));
    step(1'b0, 1'b1, "prio_release");
    check("prio_release_one", W'(1));

    // Hold at five for eight cycles.
    step(1'b1, 1'b0, "hold_rst");
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, "hold_up");
    for (int i = 0; i < 8; i++) begin
      step(1'b0, 1'b0, "hold_idle");
      check("hold_five", W'(5));
    end

    // Alternating enable counts exactly the enabled cycles.
    step(1'b1, 1'b0, "alt_rst");
    for (int i = 0; i < 12; i++) step(1'b0, 1'(i % 2), "alt");
    check("alt_six", W'(6));

    // Random enable and reset, long enough to cross several wraps.
    step(1'b1, 1'b0, "rand_rst");
    for (int i = 0; i < 60; i++) begin
      step(1'($urandom_range(0, 9) == 0), 1'($urandom_range(0, 1)), "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  // Absolute time limit so the run always ends.
  initial begin
    #100000;
    $display("FAIL timeout: observed running expected finished");
    $fatal(1, "timeout");
  end

endmodule : tb_first_counter
